// File: rtl/jt12_timer_bank.sv
`timescale 1ns/1ps
// jt12_timer_bank
// Bank of NT up-counting timers advancing on the FM tick (cen & zero).
// Each timer can run from a shared 2^PW prescaler carry, and can stop after
// one overflow or reload and keep running. Each timer has a sticky flag, a
// one-clk overflow pulse, and a share in the combined active-low IRQ.
module jt12_timer_bank #(
    parameter int NT = 2,
    parameter int CW = 10,
    parameter int PW = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_cen,
    input  logic               i_zero,
    input  logic [NT*CW-1:0]   i_value,
    input  logic [NT-1:0]      i_load,
    input  logic [NT-1:0]      i_pre_en,
    input  logic [NT-1:0]      i_oneshot,
    input  logic [NT-1:0]      i_clr_flag,
    input  logic [NT-1:0]      i_irq_en,
    output logic [NT-1:0]      o_flag,
    output logic [NT-1:0]      o_overflow,
    output logic               o_irq_n
);

    localparam logic [CW-1:0] C_CNT_ONE = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [PW-1:0] C_PRE_ONE = {{(PW-1){1'b0}}, 1'b1};

    logic          w_tick;
    logic          w_pre_carry;
    logic [PW-1:0] r_prescaler;

    assign w_tick      = i_cen & i_zero;
    assign w_pre_carry = w_tick & (&r_prescaler);

    // Shared free-running prescaler; its phase is never disturbed by timer starts.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_prescaler <= '0;
        end else if (w_tick) begin
            r_prescaler <= r_prescaler + C_PRE_ONE;
        end
    end

    for (genvar gi = 0; gi < NT; gi++) begin : g_timer
        logic [CW-1:0] w_value;
        logic          w_adv;
        logic          w_start;
        logic [CW-1:0] r_cnt;
        logic          r_running;
        logic          r_last_load;
        logic          r_overflow;
        logic          r_flag;

        assign w_value = i_value[gi*CW +: CW];
        assign w_adv   = w_tick & r_running & (i_pre_en[gi] ? w_pre_carry : 1'b1);
        assign w_start = i_load[gi] & ~r_last_load;

        // Counter state: start beats stop, stop beats terminal/count.
        // A start re-reads value, so a start landing on an all-ones count simply
        // reloads instead of producing an overflow. The overflow pulse is
        // cleared on every clk so it stays one clk wide even when ticks are sparse.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_cnt       <= '0;
                r_running   <= 1'b0;
                r_last_load <= 1'b0;
                r_overflow  <= 1'b0;
            end else begin
                r_overflow <= 1'b0;
                if (w_tick) begin
                    r_last_load <= i_load[gi];
                    if (w_start) begin
                        r_cnt     <= w_value;
                        r_running <= 1'b1;
                    end else if (!i_load[gi]) begin
                        r_running <= 1'b0;
                    end else if (w_adv) begin
                        if (&r_cnt) begin
                            r_overflow <= 1'b1;
                            r_cnt      <= w_value;
                            r_running  <= ~i_oneshot[gi];
                        end else begin
                            r_cnt <= r_cnt + C_CNT_ONE;
                        end
                    end
                end
            end
        end

        // Sticky flag, updated every clk; a clear wins over a coincident overflow.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_flag <= 1'b0;
            end else if (i_clr_flag[gi]) begin
                r_flag <= 1'b0;
            end else if (r_overflow) begin
                r_flag <= 1'b1;
            end
        end

        assign o_overflow[gi] = r_overflow;
        assign o_flag[gi]     = r_flag;
    end

    assign o_irq_n = ~|(o_flag & i_irq_en);

endmodule
